// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state encoding, direction and lamp constants for the intersection controller.
package tlc_pkg;
   typedef enum logic [2:0] {
      ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, WALK, FLASH
   } tlc_state_e;
   typedef enum logic {DIR_NS, DIR_EW} tlc_dir_e;
   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
endpackage

// File: rtl/intersection_controller_if.sv
// intersection_controller_if: bundle of the controller's request inputs and lamp/status outputs.
//   master: drives night_mode, ped_req; observes lamps and status
//   slave : receives night_mode, ped_req; drives ns_light, ew_light, flash_en, ped_walk, ped_pending
interface intersection_controller_if;
   logic       night_mode;
   logic       ped_req;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       flash_en;
   logic       ped_walk;
   logic       ped_pending;
   modport master (output night_mode, ped_req, input ns_light, ew_light, flash_en, ped_walk, ped_pending);
   modport slave  (input night_mode, ped_req, output ns_light, ew_light, flash_en, ped_walk, ped_pending);
endinterface

// File: rtl/intersection_controller_tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICKS_PER_SEC clocks, restartable by clear.
//   clock, reset_n : system clock, asynchronous active-low reset
//   clear          : restart the count from zero on the next cycle
//   tick           : high on the last cycle of each second
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 50000000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);
   localparam int CW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      tick  = cnt_q == CW'(TICKS_PER_SEC - 1);
      cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
endmodule

// File: rtl/intersection_controller.sv
// intersection_controller: two-way traffic light FSM with optional pedestrian phase and night flashing.
//   clock, reset_n         : system clock, asynchronous active-low reset
//   night_mode             : level request for flashing operation (honoured only at ALL_RED end / in FLASH)
//   ped_req                : pedestrian button, any high cycle registers a request
//   ns_light, ew_light     : {red,yellow,green} one-hot lamps
//   flash_en               : enable for downstream flashers, high only in FLASH
//   ped_walk, ped_pending  : walk signal and outstanding pedestrian request
// Build option: define TLC_PED_PHASE_EN to enable the WALK phase and request logic.
module intersection_controller
   import tlc_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int GREEN_SEC     = 20,
   parameter int YELLOW_SEC    = 3,
   parameter int ALLRED_SEC    = 1,
   parameter int WALK_SEC      = 10
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       night_mode,
   input  logic       ped_req,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       flash_en,
   output logic       ped_walk,
   output logic       ped_pending
);
   localparam int MAX_GY  = GREEN_SEC > YELLOW_SEC ? GREEN_SEC : YELLOW_SEC;
   localparam int MAX_AW  = ALLRED_SEC > WALK_SEC ? ALLRED_SEC : WALK_SEC;
   localparam int MAX_SEC = MAX_GY > MAX_AW ? MAX_GY : MAX_AW;
   localparam int SW      = $clog2(MAX_SEC + 1);

   tlc_state_e    state_q, state_d;
   tlc_dir_e      dir_q, dir_d;
   logic [SW-1:0] sec_q, sec_d, last_sec;
   logic          pend_q, pend_d;
   logic          tick, done, leave;

   tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (leave),
      .tick    (tick)
   );

   always_comb begin
      last_sec = (state_q == NS_GREEN  || state_q == EW_GREEN)  ? SW'(GREEN_SEC - 1)  :
                 (state_q == NS_YELLOW || state_q == EW_YELLOW) ? SW'(YELLOW_SEC - 1) :
                 (state_q == WALK)                              ? SW'(WALK_SEC - 1)   :
                                                                  SW'(ALLRED_SEC - 1);
      done    = tick && sec_q == last_sec;
      state_d = state_q;
      case (state_q)
         ALL_RED:              if (done) state_d = night_mode ? FLASH : pend_q ? WALK :
                                                   dir_q == DIR_NS ? NS_GREEN : EW_GREEN;
         NS_GREEN:             if (done) state_d = NS_YELLOW;
         EW_GREEN:             if (done) state_d = EW_YELLOW;
         NS_YELLOW, EW_YELLOW,
         WALK:                 if (done) state_d = ALL_RED;
         FLASH:                if (!night_mode) state_d = ALL_RED;
         default:              state_d = ALL_RED;
      endcase
      // Leaving FLASH always restarts the cycle on north-south.
      dir_d = state_d == NS_GREEN ? DIR_EW :
              state_d == EW_GREEN ? DIR_NS :
              state_q == FLASH    ? DIR_NS : dir_q;
      leave = state_d != state_q;
      // FLASH has no duration, so the seconds count is frozen there.
      sec_d = leave ? '0 : (tick && state_q != FLASH) ? sec_q + 1'b1 : sec_q;
`ifdef TLC_PED_PHASE_EN
      // A press on the WALK entry cycle survives the clear.
      pend_d   = ped_req | (pend_q & ~(leave && state_d == WALK));
      ped_walk = state_q == WALK;
`else
      pend_d   = ped_req & 1'b0;
      ped_walk = 1'b0;
`endif
      ns_light    = state_q == NS_GREEN ? LAMP_GREEN :
                    (state_q == NS_YELLOW || state_q == FLASH) ? LAMP_YELLOW : LAMP_RED;
      ew_light    = state_q == EW_GREEN ? LAMP_GREEN :
                    state_q == EW_YELLOW ? LAMP_YELLOW : LAMP_RED;
      flash_en    = state_q == FLASH;
      ped_pending = pend_q;
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state_q <= ALL_RED;
         dir_q   <= DIR_NS;
         sec_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         sec_q   <= sec_d;
         pend_q  <= pend_d;
      end
endmodule
